// File: rtl/data_mem_responder_if.sv
// Purpose: request/acknowledge bundle between the instruction translator and the data memory.
// Latency: none (wires only).
// Backpressure: the requester holds m_req and its bus values until m_ack.
interface data_mem_responder_if #(
    parameter int word_size   = 16,
    parameter int memory_addr = 16
);
    logic                   m_req;
    logic                   m_w;
    logic [memory_addr-1:0] maddr;
    logic [word_size-1:0]   mwdata;
    logic [word_size-1:0]   mrdata;
    logic                   m_ack;
    logic                   m_err;
    logic                   m_busy;
    logic [15:0]            acc_cnt;

    modport master (
        output m_req, m_w, maddr, mwdata,
        input  mrdata, m_ack, m_err, m_busy, acc_cnt
    );

    modport slave (
        input  m_req, m_w, maddr, mwdata,
        output mrdata, m_ack, m_err, m_busy, acc_cnt
    );
endinterface

// File: rtl/data_mem_responder.sv
// Purpose: DEPTH-word data memory serving LW/SW traffic, one access per req/ack handshake.
// Latency: m_ack in the cycle WAIT_STATES+1 after the capture edge; one access per WAIT_STATES+2 cycles.
// Backpressure: m_busy high while an access is in flight; bus changes are ignored until the next IDLE cycle.
module data_mem_responder #(
    parameter int word_size   = 16,
    parameter int memory_addr = 16,
    parameter int ADDR_WIDTH  = 8,
    parameter int WAIT_STATES = 2
) (
    input  logic                  dclk,
    input  logic                  rst_n,
    data_mem_responder_if.slave   bus
);
    localparam int         DEPTH = 2 ** ADDR_WIDTH;
    localparam logic [3:0] WS    = 4'(WAIT_STATES);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_RESP
    } state_t;

    state_t                 state;
    logic [3:0]             wait_cnt;
    logic                   cap_w;
    logic [memory_addr-1:0] cap_addr;
    logic [word_size-1:0]   cap_wdata;

    logic [word_size-1:0]   mem [DEPTH];

    logic                   acc_w;
    logic [memory_addr-1:0] acc_addr;
    logic [word_size-1:0]   acc_wdata;
    logic [ADDR_WIDTH-1:0]  acc_idx;
    logic                   acc_err;
    logic                   go_resp;

    // Select the access being completed: live bus values when RESP follows IDLE directly
    // (zero wait states), otherwise the copies captured at request time.
    always_comb begin
        acc_w     = cap_w;
        acc_addr  = cap_addr;
        acc_wdata = cap_wdata;
        if (state == S_IDLE) begin
            acc_w     = bus.m_w;
            acc_addr  = bus.maddr;
            acc_wdata = bus.mwdata;
        end
        acc_idx = acc_addr[ADDR_WIDTH-1:0];
        acc_err = |acc_addr[memory_addr-1:ADDR_WIDTH];
        go_resp = rst_n &&
                  (((state == S_IDLE) && bus.m_req && (WAIT_STATES == 0)) ||
                   ((state == S_WAIT) && (wait_cnt == 4'd1)));
    end

    // Array write commits on the edge entering RESP; the array itself has no reset.
    always_ff @(posedge dclk) begin
        if (go_resp && acc_w && !acc_err) begin
            mem[acc_idx] <= acc_wdata;
        end
    end

    // Access sequencer with registered handshake, read data and access counter.
    always_ff @(posedge dclk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            wait_cnt    <= 4'd0;
            cap_w       <= 1'b0;
            cap_addr    <= '0;
            cap_wdata   <= '0;
            bus.mrdata  <= '0;
            bus.m_ack   <= 1'b0;
            bus.m_err   <= 1'b0;
            bus.m_busy  <= 1'b0;
            bus.acc_cnt <= 16'd0;
        end else begin
            bus.m_ack <= 1'b0;
            bus.m_err <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (bus.m_req) begin
                        cap_w      <= bus.m_w;
                        cap_addr   <= bus.maddr;
                        cap_wdata  <= bus.mwdata;
                        wait_cnt   <= WS;
                        bus.m_busy <= 1'b1;
                        state      <= (WAIT_STATES == 0) ? S_RESP : S_WAIT;
                    end
                end
                S_WAIT: begin
                    wait_cnt <= wait_cnt - 4'd1;
                    if (wait_cnt == 4'd1) begin
                        state <= S_RESP;
                    end
                end
                S_RESP: begin
                    state      <= S_IDLE;
                    bus.m_busy <= 1'b0;
                end
                default: begin
                    state      <= S_IDLE;
                    bus.m_busy <= 1'b0;
                end
            endcase

            if (go_resp) begin
                bus.m_ack <= 1'b1;
                bus.m_err <= acc_err;
                if (!acc_err) begin
                    bus.acc_cnt <= bus.acc_cnt + 16'd1;
                end
                // Out-of-range reads return zero; writes leave the read register alone.
                if (!acc_w) begin
                    bus.mrdata <= acc_err ? '0 : mem[acc_idx];
                end
            end
        end
    end
endmodule

// File: tb/tb_data_mem_responder.sv
// Purpose: randomized self-checking bench for data_mem_responder against a word-array model.
// Latency: expects m_ack WAIT_STATES edges after capture.
// Backpressure: requester holds m_req until m_ack, then drops or re-arms it.
module tb_data_mem_responder;
    logic dclk;
    logic rst_n;

    int tests_run    = 0;
    int tests_failed = 0;
    int cyc          = 0;

    data_mem_responder_if #(.word_size(16), .memory_addr(16)) bus2 ();
    data_mem_responder_if #(.word_size(16), .memory_addr(16)) bus0 ();

    data_mem_responder #(.word_size(16), .memory_addr(16), .ADDR_WIDTH(8), .WAIT_STATES(2)) dut2 (
        .dclk  (dclk),
        .rst_n (rst_n),
        .bus   (bus2)
    );

    data_mem_responder #(.word_size(16), .memory_addr(16), .ADDR_WIDTH(8), .WAIT_STATES(0)) dut0 (
        .dclk  (dclk),
        .rst_n (rst_n),
        .bus   (bus0)
    );

    initial dclk = 1'b0;
    always #5 dclk = ~dclk;
    always @(posedge dclk) cyc <= cyc + 1;

    // Reference model: memory is an array of words, reads see the latest write,
    // out-of-range accesses do nothing except flag an error and read as zero.
    logic [15:0] model_mem [256];
    logic [15:0] model_rd;
    logic [15:0] model_acc;

    task automatic model_apply(input logic w, input logic [15:0] addr, input logic [15:0] wd,
                               output logic exp_err);
        exp_err = (addr >= 16'd256);
        if (exp_err) begin
            if (!w) model_rd = 16'h0000;
        end else begin
            if (w) model_mem[addr] = wd;
            else   model_rd = model_mem[addr];
            model_acc = model_acc + 16'd1;
        end
    endtask

    // One complete access on the WAIT_STATES=2 instance; scrambles the bus while waiting.
    task automatic do_access(input logic w, input logic [15:0] addr, input logic [15:0] wd,
                             output int lat, output logic [15:0] rd, output logic err,
                             output logic got);
        @(negedge dclk);
        bus2.m_req  = 1'b1;
        bus2.m_w    = w;
        bus2.maddr  = addr;
        bus2.mwdata = wd;
        @(posedge dclk);
        lat = 0;
        got = 1'b0;
        rd  = 16'h0;
        err = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge dclk);
            if (bus2.m_ack) begin
                got = 1'b1;
                rd  = bus2.mrdata;
                err = bus2.m_err;
            end else begin
                lat++;
                bus2.m_w    = 1'($urandom);
                bus2.maddr  = 16'($urandom);
                bus2.mwdata = 16'($urandom);
            end
        end
        bus2.m_req = 1'b0;
    endtask

    task automatic test_reset();
        rst_n       = 1'b0;
        bus2.m_req  = 1'b0; bus2.m_w = 1'b0; bus2.maddr = 16'h0; bus2.mwdata = 16'h0;
        bus0.m_req  = 1'b0; bus0.m_w = 1'b0; bus0.maddr = 16'h0; bus0.mwdata = 16'h0;
        model_acc   = 16'h0;
        model_rd    = 16'h0;
        for (int i = 0; i < 256; i++) model_mem[i] = 16'h0;
        repeat (3) @(posedge dclk);
        @(negedge dclk);
        tests_run++;
        if ({bus2.m_ack, bus2.m_err, bus2.m_busy} !== 3'b000) begin
            tests_failed++;
            $display("FAIL reset_flags: got ack/err/busy=%b required 000", {bus2.m_ack, bus2.m_err, bus2.m_busy});
        end
        tests_run++;
        if (bus2.mrdata !== 16'h0 || bus2.acc_cnt !== 16'h0) begin
            tests_failed++;
            $display("FAIL reset_data: got mrdata=%h acc=%h required 0000 0000", bus2.mrdata, bus2.acc_cnt);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_write_latency();
        int lat; logic [15:0] rd; logic err, got, exp_err;
        do_access(1'b1, 16'h0012, 16'hBEEF, lat, rd, err, got);
        model_apply(1'b1, 16'h0012, 16'hBEEF, exp_err);
        tests_run++;
        if (!got || lat != 2) begin
            tests_failed++;
            $display("FAIL write_latency: got ack=%0b after %0d edges required ack after 2", got, lat);
        end
        tests_run++;
        if (err !== exp_err || bus2.acc_cnt !== 16'd1) begin
            tests_failed++;
            $display("FAIL write_status: got err=%b acc=%0d required err=0 acc=1", err, bus2.acc_cnt);
        end
    endtask

    task automatic test_read_back();
        int lat; logic [15:0] rd; logic err, got, exp_err;
        do_access(1'b0, 16'h0012, 16'h0, lat, rd, err, got);
        model_apply(1'b0, 16'h0012, 16'h0, exp_err);
        tests_run++;
        if (!got || rd !== model_rd || err !== exp_err) begin
            tests_failed++;
            $display("FAIL read_back: got ack=%0b data=%h err=%b required data=%h err=0", got, rd, err, model_rd);
        end
        @(negedge dclk);
        tests_run++;
        if (bus2.m_ack !== 1'b0 || bus2.mrdata !== model_rd) begin
            tests_failed++;
            $display("FAIL read_hold: got ack=%b data=%h required ack=0 data=%h", bus2.m_ack, bus2.mrdata, model_rd);
        end
    endtask

    task automatic test_preload();
        int lat; logic [15:0] rd; logic err, got, exp_err;
        for (int a = 0; a < 256; a++) begin
            do_access(1'b1, 16'(a), 16'h0000, lat, rd, err, got);
            model_apply(1'b1, 16'(a), 16'h0000, exp_err);
        end
        tests_run++;
        if (bus2.acc_cnt !== model_acc) begin
            tests_failed++;
            $display("FAIL preload_count: got acc=%0d required %0d", bus2.acc_cnt, model_acc);
        end
    endtask

    task automatic test_back_to_back();
        logic        ws  [3] = '{1'b1, 1'b1, 1'b0};
        logic [15:0] as  [3] = '{16'd5, 16'd6, 16'd5};
        logic [15:0] ds  [3] = '{16'h0001, 16'h0002, 16'h0000};
        int          ack_cyc [3];
        logic [15:0] rds [3];
        logic        exp_err;
        int          idx = 0;
        @(negedge dclk);
        bus2.m_req = 1'b1; bus2.m_w = ws[0]; bus2.maddr = as[0]; bus2.mwdata = ds[0];
        for (int i = 0; i < 60 && idx < 3; i++) begin
            @(negedge dclk);
            if (bus2.m_ack) begin
                ack_cyc[idx] = cyc;
                rds[idx]     = bus2.mrdata;
                model_apply(ws[idx], as[idx], ds[idx], exp_err);
                idx++;
                if (idx < 3) begin
                    bus2.m_w = ws[idx]; bus2.maddr = as[idx]; bus2.mwdata = ds[idx];
                end else begin
                    bus2.m_req = 1'b0;
                end
            end
        end
        bus2.m_req = 1'b0;
        tests_run++;
        if (idx != 3) begin
            tests_failed++;
            $display("FAIL b2b_timeout: got %0d acks required 3", idx);
        end else begin
            tests_run++;
            if (ack_cyc[1] - ack_cyc[0] != 4 || ack_cyc[2] - ack_cyc[1] != 4) begin
                tests_failed++;
                $display("FAIL b2b_spacing: got %0d,%0d cycles required 4,4",
                         ack_cyc[1] - ack_cyc[0], ack_cyc[2] - ack_cyc[1]);
            end
            tests_run++;
            if (rds[2] !== 16'h0001) begin
                tests_failed++;
                $display("FAIL b2b_read: got %h required 0001", rds[2]);
            end
        end
        tests_run++;
        if (bus2.acc_cnt !== model_acc) begin
            tests_failed++;
            $display("FAIL b2b_count: got %0d required %0d", bus2.acc_cnt, model_acc);
        end
    endtask

    task automatic test_range_error();
        int lat; logic [15:0] rd; logic err, got, exp_err;
        do_access(1'b1, 16'h0000, 16'h5A5A, lat, rd, err, got);
        model_apply(1'b1, 16'h0000, 16'h5A5A, exp_err);
        do_access(1'b1, 16'h0100, 16'hDEAD, lat, rd, err, got);
        model_apply(1'b1, 16'h0100, 16'hDEAD, exp_err);
        tests_run++;
        if (!got || err !== 1'b1 || bus2.acc_cnt !== model_acc) begin
            tests_failed++;
            $display("FAIL range_write: got ack=%0b err=%b acc=%0d required err=1 acc=%0d", got, err, bus2.acc_cnt, model_acc);
        end
        do_access(1'b0, 16'h0100, 16'h0, lat, rd, err, got);
        model_apply(1'b0, 16'h0100, 16'h0, exp_err);
        tests_run++;
        if (!got || err !== 1'b1 || rd !== 16'h0000 || bus2.acc_cnt !== model_acc) begin
            tests_failed++;
            $display("FAIL range_read: got err=%b data=%h acc=%0d required err=1 data=0000 acc=%0d", err, rd, bus2.acc_cnt, model_acc);
        end
        do_access(1'b0, 16'h0000, 16'h0, lat, rd, err, got);
        model_apply(1'b0, 16'h0000, 16'h0, exp_err);
        tests_run++;
        if (!got || err !== 1'b0 || rd !== model_rd) begin
            tests_failed++;
            $display("FAIL range_alias: got err=%b mem0=%h required err=0 mem0=%h", err, rd, model_rd);
        end
    endtask

    task automatic test_reset_mid_access();
        int lat; logic [15:0] rd; logic err, got, exp_err;
        int acks = 0;
        do_access(1'b1, 16'h0007, 16'h7777, lat, rd, err, got);
        model_apply(1'b1, 16'h0007, 16'h7777, exp_err);
        @(negedge dclk);
        bus2.m_req = 1'b1; bus2.m_w = 1'b1; bus2.maddr = 16'h0007; bus2.mwdata = 16'h1234;
        @(posedge dclk);
        @(negedge dclk);
        tests_run++;
        if (bus2.m_busy !== 1'b1) begin
            tests_failed++;
            $display("FAIL abort_busy: got busy=%b required 1 in wait", bus2.m_busy);
        end
        rst_n = 1'b0;
        #1;
        tests_run++;
        if ({bus2.m_ack, bus2.m_err, bus2.m_busy} !== 3'b000 || bus2.acc_cnt !== 16'h0 || bus2.mrdata !== 16'h0) begin
            tests_failed++;
            $display("FAIL abort_reset: got ack/err/busy=%b acc=%h data=%h required 000 0000 0000",
                     {bus2.m_ack, bus2.m_err, bus2.m_busy}, bus2.acc_cnt, bus2.mrdata);
        end
        bus2.m_req = 1'b0;
        model_acc  = 16'h0;
        model_rd   = 16'h0;
        @(posedge dclk);
        @(negedge dclk);
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge dclk);
            if (bus2.m_ack) acks++;
        end
        tests_run++;
        if (acks != 0) begin
            tests_failed++;
            $display("FAIL abort_noack: got %0d acks required 0", acks);
        end
        do_access(1'b0, 16'h0007, 16'h0, lat, rd, err, got);
        model_apply(1'b0, 16'h0007, 16'h0, exp_err);
        tests_run++;
        if (!got || rd !== model_rd) begin
            tests_failed++;
            $display("FAIL abort_discard: got ack=%0b data=%h required %h", got, rd, model_rd);
        end
    endtask

    task automatic test_zero_wait();
        logic [15:0] val = 16'($urandom);
        for (int k = 0; k < 2; k++) begin
            @(negedge dclk);
            bus0.m_req = 1'b1; bus0.m_w = (k == 0); bus0.maddr = 16'h0000; bus0.mwdata = val;
            tests_run++;
            if (bus0.m_busy !== 1'b0) begin
                tests_failed++;
                $display("FAIL zw_idle_busy: got busy=%b required 0 before capture", bus0.m_busy);
            end
            @(posedge dclk);
            @(negedge dclk);
            bus0.m_req = 1'b0;
            tests_run++;
            if (bus0.m_ack !== 1'b1 || bus0.m_busy !== 1'b1) begin
                tests_failed++;
                $display("FAIL zw_ack: got ack=%b busy=%b required 1 1 right after capture", bus0.m_ack, bus0.m_busy);
            end
            if (k == 1) begin
                tests_run++;
                if (bus0.mrdata !== val) begin
                    tests_failed++;
                    $display("FAIL zw_read: got %h required %h", bus0.mrdata, val);
                end
            end
            @(negedge dclk);
            tests_run++;
            if (bus0.m_ack !== 1'b0 || bus0.m_busy !== 1'b0) begin
                tests_failed++;
                $display("FAIL zw_release: got ack=%b busy=%b required 0 0", bus0.m_ack, bus0.m_busy);
            end
        end
    endtask

    task automatic test_random();
        int lat; logic [15:0] rd; logic err, got, exp_err;
        logic w; logic [15:0] addr, wd;
        for (int n = 0; n < 80; n++) begin
            w    = 1'($urandom);
            wd   = 16'($urandom);
            addr = ($urandom_range(0, 7) == 0) ? {8'($urandom_range(1, 255)), 8'($urandom)}
                                               : {8'h00, 8'($urandom_range(0, 15))};
            do_access(w, addr, wd, lat, rd, err, got);
            model_apply(w, addr, wd, exp_err);
            tests_run++;
            if (!got || lat != 2 || err !== exp_err || rd !== model_rd || bus2.acc_cnt !== model_acc) begin
                tests_failed++;
                $display("FAIL rand_access n=%0d w=%b addr=%h: got ack=%0b lat=%0d err=%b data=%h acc=%0d required lat=2 err=%b data=%h acc=%0d",
                         n, w, addr, got, lat, err, rd, bus2.acc_cnt, exp_err, model_rd, model_acc);
            end
        end
    endtask

    initial begin
        test_reset();
        test_write_latency();
        test_read_back();
        test_preload();
        test_back_to_back();
        test_range_error();
        test_reset_mid_access();
        test_zero_wait();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
